// File: rtl/tmds_pkg.sv
// tmds_pkg: shared constants for the TMDS channel decoder (tokens, FSM states, widths).
// Latency: n/a, constants and types only.
// Backpressure: n/a.
package tmds_pkg;

    // DVI control tokens, written bit 9 .. bit 0. Bit 0 is the earliest serial bit.
    localparam logic [9:0] TOKEN_CTL00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_CTL01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_CTL10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_CTL11 = 10'b1010101011;

    // Counter widths. CNT_W must hold the largest of LOCK_TOKENS,
    // SEARCH_TIMEOUT and TOKEN_TIMEOUT.
    localparam int CNT_W    = 16;
    localparam int OFFSET_W = 4;
    localparam int STATS_W  = 8;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: maps one aligned 10-bit TMDS word to {video byte, control bits, is_token}.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: i_word aligned 10-bit word; o_vd decoded video byte; o_cd control bits
//        {vSync,hSync}; o_is_token high when i_word is one of the four control tokens.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] i_word,
    output logic [7:0] o_vd,
    output logic [1:0] o_cd,
    output logic       o_is_token
);

    // Bit 9 flags that the encoder inverted the payload.
    logic [7:0] w_q;
    assign w_q = i_word[9] ? ~i_word[7:0] : i_word[7:0];

    // Bit 8 selects whether the encoder chained the bits with XOR (1) or XNOR (0).
    always_comb begin
        o_vd    = 8'h00;
        o_vd[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            o_vd[i] = i_word[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
        end
    end

    always_comb begin
        o_is_token = 1'b1;
        o_cd       = 2'b00;
        case (i_word)
            TOKEN_CTL00: o_cd = 2'b00;
            TOKEN_CTL01: o_cd = 2'b01;
            TOKEN_CTL10: o_cd = 2'b10;
            TOKEN_CTL11: o_cd = 2'b11;
            default:     o_is_token = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: word-aligns a deserialized TMDS stream, locks on control tokens, decodes video/control.
// Latency: 2 pixclk cycles from the aligned word to vd/cd/vde (stage 1 register, stage 2 register).
// Backpressure: none; one word accepted and one result produced every pixclk.
// Ports: pixclk clock; rst sync active-high reset; tmds_raw unaligned word (bit 0 earliest);
//        vd/cd/vde decoded outputs (zero while unlocked); locked alignment achieved;
//        offset current bit-slip 0..9; relock_cnt lock-loss counter.
// Optional: define TMDS_DEC_STATS_EN to build the saturating relock_cnt counter;
//           otherwise relock_cnt is tied to zero.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS    = 32,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int TOKEN_TIMEOUT  = 2048
) (
    input  logic         pixclk,
    input  logic         rst,
    input  logic [9:0]   tmds_raw,
    output logic [7:0]   vd,
    output logic [1:0]   cd,
    output logic         vde,
    output logic         locked,
    output logic [3:0]   offset,
    output logic [7:0]   relock_cnt
);

    localparam logic [CNT_W-1:0]    LOCK_LAST   = CNT_W'(LOCK_TOKENS - 1);
    localparam logic [CNT_W-1:0]    SEARCH_LAST = CNT_W'(SEARCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    IDLE_LAST   = CNT_W'(TOKEN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [OFFSET_W-1:0] OFFSET_MAX  = OFFSET_W'(9);

    logic [9:0]          r_prev;
    logic [9:0]          r_stage1;
    state_t              r_state;
    logic [OFFSET_W-1:0] r_offset;
    logic [CNT_W-1:0]    r_tok_run;
    logic [CNT_W-1:0]    r_search_tmr;
    logic [CNT_W-1:0]    r_idle_tmr;
    logic [7:0]          r_vd;
    logic [1:0]          r_cd;
    logic                r_vde;

    logic [19:0]         w_window;
    logic [9:0]          w_aligned;
    logic [7:0]          w_dec_vd;
    logic [1:0]          w_dec_cd;
    logic                w_is_token;
    logic [OFFSET_W-1:0] w_offset_inc;

    state_t              w_state_nxt;
    logic [OFFSET_W-1:0] w_offset_nxt;
    logic [CNT_W-1:0]    w_tok_run_nxt;
    logic [CNT_W-1:0]    w_search_tmr_nxt;
    logic [CNT_W-1:0]    w_idle_tmr_nxt;

    // Two consecutive words give a 20-bit window; any 10-bit slice of it at
    // offset 0..9 is a candidate word boundary. Offset 0 selects r_prev.
    assign w_window  = {tmds_raw, r_prev};
    assign w_aligned = 10'(w_window >> r_offset);

    tmds_symbol_decode u_symbol_decode (
        .i_word     (r_stage1),
        .o_vd       (w_dec_vd),
        .o_cd       (w_dec_cd),
        .o_is_token (w_is_token)
    );

    assign w_offset_inc = (r_offset == OFFSET_MAX) ? '0 : r_offset + OFFSET_W'(1);

    always_comb begin
        w_state_nxt      = r_state;
        w_offset_nxt     = r_offset;
        w_tok_run_nxt    = r_tok_run;
        w_search_tmr_nxt = r_search_tmr;
        w_idle_tmr_nxt   = r_idle_tmr;
        case (r_state)
            ST_SEARCH: begin
                // Lock is checked first so a lock landing on the timeout
                // cycle keeps the offset that produced it.
                if (w_is_token && (r_tok_run == LOCK_LAST)) begin
                    w_state_nxt      = ST_LOCKED;
                    w_tok_run_nxt    = '0;
                    w_search_tmr_nxt = '0;
                    w_idle_tmr_nxt   = '0;
                end else if (r_search_tmr == SEARCH_LAST) begin
                    w_offset_nxt     = w_offset_inc;
                    w_tok_run_nxt    = '0;
                    w_search_tmr_nxt = '0;
                end else begin
                    w_search_tmr_nxt = r_search_tmr + CNT_ONE;
                    w_tok_run_nxt    = w_is_token ? (r_tok_run + CNT_ONE) : '0;
                end
            end
            ST_LOCKED: begin
                if (w_is_token) begin
                    w_idle_tmr_nxt = '0;
                end else if (r_idle_tmr == IDLE_LAST) begin
                    w_state_nxt      = ST_SEARCH;
                    w_offset_nxt     = w_offset_inc;
                    w_tok_run_nxt    = '0;
                    w_search_tmr_nxt = '0;
                    w_idle_tmr_nxt   = '0;
                end else begin
                    w_idle_tmr_nxt = r_idle_tmr + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            r_prev       <= '0;
            r_stage1     <= '0;
            r_state      <= ST_SEARCH;
            r_offset     <= '0;
            r_tok_run    <= '0;
            r_search_tmr <= '0;
            r_idle_tmr   <= '0;
            r_vd         <= '0;
            r_cd         <= '0;
            r_vde        <= 1'b0;
        end else begin
            r_prev       <= tmds_raw;
            r_stage1     <= w_aligned;
            r_state      <= w_state_nxt;
            r_offset     <= w_offset_nxt;
            r_tok_run    <= w_tok_run_nxt;
            r_search_tmr <= w_search_tmr_nxt;
            r_idle_tmr   <= w_idle_tmr_nxt;
            // Outputs follow the state being entered so they are zero in
            // exactly the cycles where locked is low.
            if (w_state_nxt == ST_LOCKED) begin
                if (w_is_token) begin
                    r_vde <= 1'b0;
                    r_cd  <= w_dec_cd;
                end else begin
                    r_vde <= 1'b1;
                    r_vd  <= w_dec_vd;
                end
            end else begin
                r_vde <= 1'b0;
                r_vd  <= '0;
                r_cd  <= '0;
            end
        end
    end

    assign vd     = r_vd;
    assign cd     = r_cd;
    assign vde    = r_vde;
    assign locked = (r_state == ST_LOCKED);
    assign offset = r_offset;

`ifdef TMDS_DEC_STATS_EN
    logic [STATS_W-1:0] r_relock_cnt;
    logic               w_lock_lost;

    assign w_lock_lost = (r_state == ST_LOCKED) && (w_state_nxt == ST_SEARCH);

    always_ff @(posedge pixclk) begin
        if (rst) begin
            r_relock_cnt <= '0;
        end else if (w_lock_lost && (r_relock_cnt != {STATS_W{1'b1}})) begin
            r_relock_cnt <= r_relock_cnt + STATS_W'(1);
        end
    end

    assign relock_cnt = r_relock_cnt;
`else
    assign relock_cnt = '0;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: bit-serial TMDS stream generator with scoreboard for tmds_channel_decoder.
// Latency: expects results 2 cycles after the word's capture edge.
// Backpressure: none.
module tb_tmds_channel_decoder;

    logic       pixclk;
    logic       rst;
    logic [9:0] tmds_raw;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       locked;
    logic [3:0] offset;
    logic [7:0] relock_cnt;

    tmds_channel_decoder dut (
        .pixclk     (pixclk),
        .rst        (rst),
        .tmds_raw   (tmds_raw),
        .vd         (vd),
        .cd         (cd),
        .vde        (vde),
        .locked     (locked),
        .offset     (offset),
        .relock_cnt (relock_cnt)
    );

`ifdef TMDS_DEC_STATS_EN
    localparam logic [7:0] EXP_RELOCK = 8'd1;
`else
    localparam logic [7:0] EXP_RELOCK = 8'd0;
`endif

    typedef struct {
        int         due;
        bit         chk;
        logic       lk;
        logic       vde;
        logic [7:0] vd;
        logic [1:0] cd;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         checks;
    int         failures;
    int         edge_cnt;
    int         enc_disp;
    int         rot;
    logic [9:0] prev_sym;
    logic [7:0] hold_vd;
    logic [1:0] hold_cd;

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    initial edge_cnt = 0;
    always @(posedge pixclk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Scoreboard: each pushed word names the edge after which its result must show.
    always @(negedge pixclk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
            mon_e = sb_q.pop_front();
            if (mon_e.chk) begin
                checks++;
                if (mon_e.due != edge_cnt) begin
                    failures++;
                    $display("FAIL sb_stale due=%0d now=%0d", mon_e.due, edge_cnt);
                end else if ({locked, vde, vd, cd} !== {mon_e.lk, mon_e.vde, mon_e.vd, mon_e.cd}) begin
                    failures++;
                    $display("FAIL sb_word edge=%0d got lk/vde/vd/cd=%b/%b/%h/%h exp=%b/%b/%h/%h",
                             edge_cnt, locked, vde, vd, cd, mon_e.lk, mon_e.vde, mon_e.vd, mon_e.cd);
                end
            end
        end
    end

    function automatic logic [9:0] token_of(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = 10'b1101010100;
            2'b01:   t = 10'b0010101011;
            2'b10:   t = 10'b0101010100;
            default: t = 10'b1010101011;
        endcase
        return t;
    endfunction

    // Reference DVI data encoder with running disparity.
    function automatic logic [9:0] tmds_encode(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] q;
        int         n1d;
        int         n1q;
        int         n0q;
        logic       use_xnor;
        n1d      = $countones(d);
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        n1q   = $countones(qm[7:0]);
        n0q   = 8 - n1q;
        if (enc_disp == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8]) enc_disp += n1q - n0q;
            else       enc_disp += n0q - n1q;
        end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_disp += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_disp += -2 * int'(!qm[8]) + n1q - n0q;
        end
        return q;
    endfunction

    // Serial stream delayed by rot bits, cut into 10-bit words: word boundaries sit at bit rot.
    function automatic logic [9:0] rot_word(input logic [9:0] cur, input logic [9:0] prv, input int r);
        logic [19:0] cat;
        cat = {cur, prv};
        cat = cat >> (10 - r);
        return cat[9:0];
    endfunction

    task automatic drive(input logic [9:0] sym, input bit is_tok, input logic [7:0] val,
                         input bit chk, input logic lk);
        exp_t e;
        tmds_raw = rot_word(sym, prev_sym, rot);
        prev_sym = sym;
        e.due = edge_cnt + 3;
        e.chk = chk;
        e.lk  = lk;
        if (!lk) begin
            hold_vd = 8'h00;
            hold_cd = 2'b00;
            e.vde   = 1'b0;
        end else if (is_tok) begin
            hold_cd = val[1:0];
            e.vde   = 1'b0;
        end else begin
            hold_vd = val;
            e.vde   = 1'b1;
        end
        e.vd = hold_vd;
        e.cd = hold_cd;
        sb_q.push_back(e);
        @(posedge pixclk);
        #1;
    endtask

    task automatic drive_tok(input logic [1:0] c, input bit chk, input logic lk);
        drive(token_of(c), 1'b1, {6'd0, c}, chk, lk);
    endtask

    task automatic drive_vid(input logic [7:0] b, input bit chk, input logic lk);
        drive(tmds_encode(b), 1'b0, b, chk, lk);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        tmds_raw = 10'h2AA;
        prev_sym = 10'h000;
        hold_vd  = 8'h00;
        hold_cd  = 2'b00;
        sb_q.delete();
        repeat (3) @(posedge pixclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (locked !== 1'b0)     begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (offset !== 4'd0)     begin failures++; $display("FAIL reset_offset got=%0d exp=0", offset); end
        checks++; if (vde !== 1'b0)        begin failures++; $display("FAIL reset_vde got=%b exp=0", vde); end
        checks++; if (vd !== 8'h00)        begin failures++; $display("FAIL reset_vd got=%h exp=00", vd); end
        checks++; if (cd !== 2'b00)        begin failures++; $display("FAIL reset_cd got=%b exp=00", cd); end
        checks++; if (relock_cnt !== 8'd0) begin failures++; $display("FAIL reset_relock got=%0d exp=0", relock_cnt); end
    endtask

    task automatic test_lock_aligned();
        int tok32_edge;
        int rise_edge;
        rot        = 0;
        tok32_edge = -1;
        rise_edge  = -1;
        for (int i = 1; i <= 160; i++) begin
            drive_tok(2'b00, 1'b1, (i >= 32));
            if (i == 32) tok32_edge = edge_cnt;
            if (locked === 1'b1 && rise_edge < 0) rise_edge = edge_cnt;
        end
        checks++;
        if (rise_edge != tok32_edge + 2) begin
            failures++;
            $display("FAIL lock_rise_edge got=%0d exp=%0d", rise_edge, tok32_edge + 2);
        end
        for (int i = 0; i < 30; i++) drive_vid(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    endtask

    task automatic test_video_latency();
        int e_a5;
        drive_vid(8'h3C, 1'b1, 1'b1);
        drive_vid(8'hA5, 1'b1, 1'b1);
        e_a5 = edge_cnt;
        drive_vid(8'h5A, 1'b1, 1'b1);
        checks++;
        if (vd !== 8'h3C) begin failures++; $display("FAIL a5_early edge=%0d got=%h exp=3c", edge_cnt - e_a5, vd); end
        drive_vid(8'h0F, 1'b1, 1'b1);
        checks++;
        if ({vde, vd} !== {1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL a5_latency got vde/vd=%b/%h exp=1/a5", vde, vd);
        end
        drive_vid(8'h00, 1'b1, 1'b1);
        drive_vid(8'hFF, 1'b1, 1'b1);
    endtask

    task automatic test_search_rotated();
        int last_chg;
        int steps;
        logic [3:0] last_off;
        apply_reset();
        rot      = 7;
        steps    = 0;
        last_off = 4'd0;
        last_chg = edge_cnt;
        for (int n = 0; n < 9000; n++) begin
            drive_tok(2'b00, 1'b0, 1'b0);
            if (offset !== last_off) begin
                steps++;
                checks++;
                if ((edge_cnt - last_chg) != 1024 || offset !== last_off + 4'd1) begin
                    failures++;
                    $display("FAIL search_step off=%0d interval=%0d exp_off=%0d exp_interval=1024",
                             offset, edge_cnt - last_chg, last_off + 4'd1);
                end
                last_chg = edge_cnt;
                last_off = offset;
            end
            if (locked === 1'b1) break;
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL search_lock_timeout locked=%b exp=1", locked); end
        checks++; if (offset !== 4'd7) begin failures++; $display("FAIL search_lock_offset got=%0d exp=7", offset); end
        checks++; if (steps != 7)      begin failures++; $display("FAIL search_steps got=%0d exp=7", steps); end
        for (int i = 0; i < 20; i++) drive_vid(8'($urandom_range(0, 255)), 1'b1, 1'b1);
        drive_tok(2'b10, 1'b1, 1'b1);
        drive_vid(8'h81, 1'b1, 1'b1);
        drive_tok(2'b01, 1'b1, 1'b1);
        drive_tok(2'b11, 1'b1, 1'b1);
        drive_vid(8'h7E, 1'b1, 1'b1);
        drive_vid(8'hC3, 1'b1, 1'b1);
    endtask

    task automatic test_token_timeout();
        drive_tok(2'b00, 1'b1, 1'b1);
        for (int j = 1; j <= 2048; j++) drive_vid(8'($urandom_range(0, 255)), 1'b1, (j < 2048));
        drive_vid(8'h11, 1'b0, 1'b0);
        checks++;
        if ({locked, offset} !== {1'b1, 4'd7}) begin
            failures++;
            $display("FAIL timeout_early got locked/offset=%b/%0d exp=1/7", locked, offset);
        end
        drive_vid(8'h22, 1'b0, 1'b0);
        checks++;
        if ({locked, offset} !== {1'b0, 4'd8}) begin
            failures++;
            $display("FAIL timeout_drop got locked/offset=%b/%0d exp=0/8", locked, offset);
        end
        checks++;
        if (relock_cnt !== EXP_RELOCK) begin
            failures++;
            $display("FAIL timeout_relock got=%0d exp=%0d", relock_cnt, EXP_RELOCK);
        end
    endtask

    task automatic test_reset_while_locked();
        apply_reset();
        rot = 5;
        for (int n = 0; n < 7000; n++) begin
            drive_tok(2'b00, 1'b0, 1'b0);
            if (locked === 1'b1) break;
        end
        checks++;
        if ({locked, offset} !== {1'b1, 4'd5}) begin
            failures++;
            $display("FAIL rot5_lock got locked/offset=%b/%0d exp=1/5", locked, offset);
        end
        drive_vid(8'hC3, 1'b1, 1'b1);
        drive_vid(8'h7E, 1'b1, 1'b1);
        drive_vid(8'h81, 1'b1, 1'b1);
        drive_vid(8'h99, 1'b1, 1'b1);
        drive_vid(8'h42, 1'b1, 1'b1);
        sb_q.delete();
        rst = 1'b1;
        @(posedge pixclk);
        #1;
        checks++;
        if ({offset, locked, vde, vd, cd} !== {4'd0, 1'b0, 1'b0, 8'h00, 2'b00}) begin
            failures++;
            $display("FAIL midlock_reset got off/lk/vde/vd/cd=%0d/%b/%b/%h/%b exp=0/0/0/00/00",
                     offset, locked, vde, vd, cd);
        end
        checks++;
        if (relock_cnt !== 8'd0) begin failures++; $display("FAIL midlock_reset_relock got=%0d exp=0", relock_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_lock_at_timeout_edge();
        apply_reset();
        rot = 0;
        for (int i = 1; i <= 990; i++) drive_vid(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        for (int t = 1; t <= 40; t++) begin
            drive_tok(2'b00, 1'b1, (t >= 32));
            if (t == 33) begin
                checks++;
                if ({locked, offset} !== {1'b0, 4'd0}) begin
                    failures++;
                    $display("FAIL edge_prelock got locked/offset=%b/%0d exp=0/0", locked, offset);
                end
            end
            if (t == 34) begin
                checks++;
                if ({locked, offset} !== {1'b1, 4'd0}) begin
                    failures++;
                    $display("FAIL edge_lock_priority got locked/offset=%b/%0d exp=1/0", locked, offset);
                end
            end
        end
        drive_vid(8'h5A, 1'b1, 1'b1);
        drive_vid(8'hA5, 1'b1, 1'b1);
        drive_vid(8'h00, 1'b1, 1'b1);
        drive_vid(8'h00, 1'b1, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        enc_disp = 0;
        rot      = 0;
        rst      = 1'b1;
        tmds_raw = 10'h000;
        prev_sym = 10'h000;
        hold_vd  = 8'h00;
        hold_cd  = 2'b00;
        test_reset();
        test_lock_aligned();
        test_video_latency();
        test_search_rotated();
        test_token_timeout();
        test_reset_while_locked();
        test_lock_at_timeout_edge();
        repeat (3) @(posedge pixclk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain left=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
